adc_current_cal: RTL and testbench

Downstream stage of the AD7606 sampling controller in the FOC current path. It consumes the three raw phase-current words and their `done` strobe, and learns a per-channel zero-current offset by averaging a fixed number of samples. At run time it subtracts the offsets with saturation and emits signed phase currents plus a consistency flag to the Clarke/Park stage.

---
 rtl/adc_current_cal.sv | 146 ++++++++++++++
 tb/tb_adc_current_cal.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_current_cal.sv
// Phase-current offset calibration: averages 2^CAL_SHIFT samples per channel to learn
// the zero-current offset, then subtracts it with saturation and flags |ia+ib+ic| excess.
module adc_current_cal #(
    parameter int unsigned CAL_SHIFT = 6,
    parameter bit          AUTO_CAL  = 1'b1,
    parameter logic [15:0] SUM_LIM   = 16'd2048
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               adc_done,
    input  logic [15:0]        ch1,
    input  logic [15:0]        ch2,
    input  logic [15:0]        ch3,
    input  logic               cal_req,
    output logic signed [15:0] ia,
    output logic signed [15:0] ib,
    output logic signed [15:0] ic,
    output logic               out_valid,
    output logic               sum_err,
    output logic               cal_busy,
    output logic               cal_done,
    output logic signed [15:0] off_a,
    output logic signed [15:0] off_b,
    output logic signed [15:0] off_c
);
    localparam int unsigned AW = 16 + CAL_SHIFT;
    localparam int unsigned CW = CAL_SHIFT + 1;
    localparam logic [CW-1:0] LAST = CW'((1 << CAL_SHIFT) - 1);

    typedef enum logic [1:0] {S_UNCAL, S_CAL, S_RUN} state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic signed [AW-1:0]  acc_a_q, acc_b_q, acc_c_q;
    logic signed [AW-1:0]  acc_a_d, acc_b_d, acc_c_d;
    logic signed [15:0]    ia_q, ib_q, ic_q, off_a_q, off_b_q, off_c_q;
    logic signed [15:0]    ia_d, ib_d, ic_d;
    logic signed [17:0]    sum_d;
    logic signed [17:0]    lim;
    logic                  err_d;
    logic                  ov_q, err_q, busy_q, done_q;

    function automatic logic signed [15:0] sat16(input logic signed [16:0] d);
        if (d > 17'sd32767) begin
            return 16'sh7fff;
        end else if (d < -17'sd32768) begin
            return 16'sh8000;
        end else begin
            return d[15:0];
        end
    endfunction

    // Datapath: accumulate during calibration, subtract/saturate/sum at run time
    always_comb begin
        acc_a_d = acc_a_q + AW'($signed(ch1));
        acc_b_d = acc_b_q + AW'($signed(ch2));
        acc_c_d = acc_c_q + AW'($signed(ch3));
        ia_d    = sat16(17'($signed(ch1)) - 17'(off_a_q));
        ib_d    = sat16(17'($signed(ch2)) - 17'(off_b_q));
        ic_d    = sat16(17'($signed(ch3)) - 17'(off_c_q));
        sum_d   = 18'(ia_d) + 18'(ib_d) + 18'(ic_d);
        lim     = $signed({2'b00, SUM_LIM});
        err_d   = (sum_d > lim) || (sum_d < -lim);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= AUTO_CAL ? S_CAL : S_UNCAL;
            cnt_q   <= '0;
            acc_a_q <= '0;
            acc_b_q <= '0;
            acc_c_q <= '0;
            ia_q    <= '0;
            ib_q    <= '0;
            ic_q    <= '0;
            off_a_q <= '0;
            off_b_q <= '0;
            off_c_q <= '0;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= AUTO_CAL;
            done_q  <= 1'b0;
        end else begin
            ov_q  <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_UNCAL: begin
                    if (cal_req) begin
                        state_q <= S_CAL;
                        cnt_q   <= '0;
                        acc_a_q <= '0;
                        acc_b_q <= '0;
                        acc_c_q <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_CAL: begin
                    if (adc_done) begin
                        acc_a_q <= acc_a_d;
                        acc_b_q <= acc_b_d;
                        acc_c_q <= acc_c_d;
                        cnt_q   <= cnt_q + CW'(1);
                        if (cnt_q == LAST) begin
                            off_a_q <= 16'(acc_a_d >>> CAL_SHIFT);
                            off_b_q <= 16'(acc_b_d >>> CAL_SHIFT);
                            off_c_q <= 16'(acc_c_d >>> CAL_SHIFT);
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // A recalibration request pre-empts a coincident sample
                    if (cal_req) begin
                        state_q <= S_CAL;
                        cnt_q   <= '0;
                        acc_a_q <= '0;
                        acc_b_q <= '0;
                        acc_c_q <= '0;
                        busy_q  <= 1'b1;
                    end else if (adc_done) begin
                        ia_q  <= ia_d;
                        ib_q  <= ib_d;
                        ic_q  <= ic_d;
                        ov_q  <= 1'b1;
                        err_q <= err_d;
                    end
                end
                default: state_q <= S_UNCAL;
            endcase
        end
    end

    assign ia        = ia_q;
    assign ib        = ib_q;
    assign ic        = ic_q;
    assign out_valid = ov_q;
    assign sum_err   = err_q;
    assign cal_busy  = busy_q;
    assign cal_done  = done_q;
    assign off_a     = off_a_q;
    assign off_b     = off_b_q;
    assign off_c     = off_c_q;
endmodule

// File: tb/tb_adc_current_cal.sv
// Bench for adc_current_cal: table vectors, hand sequences for calibration corners,
// and random strobes checked against an integer-arithmetic reference model.
module tb_adc_current_cal;
    localparam int NS = 4;  // samples per calibration (CAL_SHIFT = 2)

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1_n, rst0_n, adc_done, cal_req, sel_b, cal_req1, cal_req0;
    logic [15:0] ch1, ch2, ch3;
    logic signed [15:0] ia1, ib1, ic1, oa1, ob1, oc1;
    logic signed [15:0] ia0, ib0, ic0, oa0, ob0, oc0;
    logic ov1, er1, busy1, done1, ov0, er0, busy0, done0;

    assign cal_req1 = cal_req & ~sel_b;
    assign cal_req0 = cal_req & sel_b;

    adc_current_cal #(.CAL_SHIFT(2), .AUTO_CAL(1'b1), .SUM_LIM(16'd2048)) dut1 (
        .clk(clk), .rst_n(rst1_n), .adc_done(adc_done), .ch1(ch1), .ch2(ch2), .ch3(ch3),
        .cal_req(cal_req1), .ia(ia1), .ib(ib1), .ic(ic1), .out_valid(ov1), .sum_err(er1),
        .cal_busy(busy1), .cal_done(done1), .off_a(oa1), .off_b(ob1), .off_c(oc1));

    adc_current_cal #(.CAL_SHIFT(2), .AUTO_CAL(1'b0), .SUM_LIM(16'd2048)) dut0 (
        .clk(clk), .rst_n(rst0_n), .adc_done(adc_done), .ch1(ch1), .ch2(ch2), .ch3(ch3),
        .cal_req(cal_req0), .ia(ia0), .ib(ib0), .ic(ic0), .out_valid(ov0), .sum_err(er0),
        .cal_busy(busy0), .cal_done(done0), .off_a(oa0), .off_b(ob0), .off_c(oc0));

    int n_tests = 0;
    int n_fail  = 0;
    int m_off[3];

    typedef struct {
        int a, b, c;
        int ea, eb, ec, eerr;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int floor_avg(input int sum, input int n);
        int q;
        q = sum / n;
        if ((sum % n != 0) && (sum < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int abs_i(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // One-cycle strobe; returns at the falling edge after the sampling edge
    task automatic strobe(input int a, input int b, input int c);
        @(negedge clk);
        adc_done = 1'b1;
        ch1 = 16'(a);
        ch2 = 16'(b);
        ch3 = 16'(c);
        @(negedge clk);
        adc_done = 1'b0;
    endtask

    task automatic pulse_req(input bit with_strobe, input int a, input int b, input int c);
        @(negedge clk);
        cal_req  = 1'b1;
        adc_done = with_strobe;
        ch1 = 16'(a);
        ch2 = 16'(b);
        ch3 = 16'(c);
        @(negedge clk);
        cal_req  = 1'b0;
        adc_done = 1'b0;
    endtask

    task automatic run_chk(input int a, input int b, input int c);
        int ea, eb, ec;
        ea = clamp16(a - m_off[0]);
        eb = clamp16(b - m_off[1]);
        ec = clamp16(c - m_off[2]);
        strobe(a, b, c);
        chk("rand_ov", int'(ov1), 1);
        chk("rand_ia", int'(ia1), ea);
        chk("rand_ib", int'(ib1), eb);
        chk("rand_ic", int'(ic1), ec);
        chk("rand_err", int'(er1), (abs_i(ea + eb + ec) > 2048) ? 1 : 0);
        @(negedge clk);
        chk("rand_ov_pulse", int'(ov1), 0);
    endtask

    task automatic cal_rand();
        int sum[3];
        int v[3];
        sum = '{0, 0, 0};
        pulse_req(1'b0, 0, 0, 0);
        chk("rcal_busy_start", int'(busy1), 1);
        for (int k = 0; k < NS; k++) begin
            for (int j = 0; j < 3; j++) begin
                v[j] = int'($urandom_range(8000)) - 4000;
                sum[j] += v[j];
            end
            strobe(v[0], v[1], v[2]);
            chk("rcal_no_ov", int'(ov1), 0);
            if (k < NS - 1) chk("rcal_busy", int'(busy1), 1);
        end
        for (int j = 0; j < 3; j++) m_off[j] = floor_avg(sum[j], NS);
        chk("rcal_off_a", int'(oa1), m_off[0]);
        chk("rcal_off_b", int'(ob1), m_off[1]);
        chk("rcal_off_c", int'(oc1), m_off[2]);
        chk("rcal_busy_end", int'(busy1), 0);
        chk("rcal_done", int'(done1), 1);
    endtask

    initial begin
        // offsets 103 / -10 / 0 in force for these vectors
        tbl[0] = '{1103, -510, -600, 1000, -500, -600, 0};
        tbl[1] = '{103, -10, 0, 0, 0, 0, 0};
        tbl[2] = '{-32768, 32767, 0, -32768, 32767, 0, 0};
        tbl[3] = '{3103, -10, 0, 3000, 0, 0, 1};
        tbl[4] = '{2151, -10, 0, 2048, 0, 0, 0};
        tbl[5] = '{2152, -10, 0, 2049, 0, 0, 1};
        tbl[6] = '{-1945, -10, 0, -2048, 0, 0, 0};
        tbl[7] = '{-1946, -10, 0, -2049, 0, 0, 1};

        rst1_n = 1'b0; rst0_n = 1'b0; adc_done = 1'b0; cal_req = 1'b0; sel_b = 1'b0;
        ch1 = '0; ch2 = '0; ch3 = '0;
        repeat (2) @(negedge clk);
        rst1_n = 1'b1; rst0_n = 1'b1;
        chk("rst_busy1", int'(busy1), 1);
        chk("rst_done1", int'(done1), 0);
        chk("rst_ov1", int'(ov1), 0);
        chk("rst_ia1", int'(ia1), 0);
        chk("rst_offa1", int'(oa1), 0);
        chk("rst_busy0", int'(busy0), 0);

        // Auto calibration straight out of reset
        for (int k = 0; k < NS; k++) begin
            strobe(100 + 2 * k, -10, 0);
            chk("acal_no_ov", int'(ov1), 0);
            chk("uncal_no_ov", int'(ov0), 0);
            if (k < NS - 1) chk("acal_busy", int'(busy1), 1);
        end
        chk("acal_off_a", int'(oa1), 103);
        chk("acal_off_b", int'(ob1), -10);
        chk("acal_off_c", int'(oc1), 0);
        chk("acal_done", int'(done1), 1);
        chk("acal_busy", int'(busy1), 0);

        foreach (tbl[i]) begin
            strobe(tbl[i].a, tbl[i].b, tbl[i].c);
            chk("vec_ov", int'(ov1), 1);
            chk("vec_ia", int'(ia1), tbl[i].ea);
            chk("vec_ib", int'(ib1), tbl[i].eb);
            chk("vec_ic", int'(ic1), tbl[i].ec);
            chk("vec_err", int'(er1), tbl[i].eerr);
            repeat (2) @(negedge clk);
            chk("vec_ov_pulse", int'(ov1), 0);
            chk("vec_hold_ia", int'(ia1), tbl[i].ea);
        end

        // Recalibration request coincident with a strobe; request during CAL ignored
        pulse_req(1'b1, 5000, 5000, 5000);
        chk("recal_no_ov", int'(ov1), 0);
        chk("recal_busy", int'(busy1), 1);
        chk("recal_done_kept", int'(done1), 1);
        chk("recal_off_held", int'(oa1), 103);
        strobe(-200, 300, 0);
        strobe(-200, 300, 0);
        pulse_req(1'b0, 0, 0, 0);
        strobe(-200, 300, 0);
        chk("recal_busy3", int'(busy1), 1);
        chk("recal_off_held3", int'(oa1), 103);
        chk("recal_no_ov3", int'(ov1), 0);
        strobe(-200, 300, 0);
        chk("recal_off_a", int'(oa1), -200);
        chk("recal_off_b", int'(ob1), 300);
        chk("recal_off_c", int'(oc1), 0);
        chk("recal_busy_end", int'(busy1), 0);

        strobe(32700, -32700, 5000);
        chk("sat_ia", int'(ia1), 32767);
        chk("sat_ib", int'(ib1), -32768);
        chk("sat_ic", int'(ic1), 5000);
        chk("sat_err", int'(er1), 1);

        // Negative averages round toward -inf
        pulse_req(1'b0, 0, 0, 0);
        strobe(-1, 5, -3);
        strobe(-1, 6, -3);
        strobe(-1, 6, -3);
        strobe(-2, 6, -3);
        chk("neg_off_a", int'(oa1), -2);
        chk("neg_off_b", int'(ob1), 5);
        chk("neg_off_c", int'(oc1), -3);
        m_off = '{-2, 5, -3};

        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(19) == 0) begin
                cal_rand();
            end else begin
                int v[3];
                for (int j = 0; j < 3; j++) begin
                    if ($urandom_range(3) == 0) v[j] = int'($urandom_range(65535)) - 32768;
                    else v[j] = m_off[j] + int'($urandom_range(6000)) - 3000;
                    v[j] = clamp16(v[j]);
                end
                run_chk(v[0], v[1], v[2]);
            end
        end

        // Reset mid-calibration on the manual-calibration instance
        sel_b = 1'b1;
        pulse_req(1'b0, 0, 0, 0);
        chk("mcal_busy", int'(busy0), 1);
        strobe(500, 500, 500);
        strobe(500, 500, 500);
        chk("mcal_no_ov", int'(ov0), 0);
        @(negedge clk);
        rst0_n = 1'b0;
        @(negedge clk);
        rst0_n = 1'b1;
        chk("mrst_busy", int'(busy0), 0);
        chk("mrst_done", int'(done0), 0);
        chk("mrst_ov", int'(ov0), 0);
        chk("mrst_err", int'(er0), 0);
        chk("mrst_ia", int'(ia0), 0);
        chk("mrst_ib", int'(ib0), 0);
        chk("mrst_ic", int'(ic0), 0);
        chk("mrst_offa", int'(oa0), 0);
        chk("mrst_offb", int'(ob0), 0);
        chk("mrst_offc", int'(oc0), 0);
        for (int k = 0; k < NS; k++) begin
            strobe(700, 700, 700);
            chk("mrst_uncal_ov", int'(ov0), 0);
        end
        chk("mrst_uncal_done", int'(done0), 0);
        pulse_req(1'b0, 0, 0, 0);
        strobe(10, 0, -7);
        strobe(20, 0, -7);
        strobe(30, 0, -7);
        strobe(40, 0, -8);
        chk("mcal_done", int'(done0), 1);
        chk("mcal_off_a", int'(oa0), 25);
        chk("mcal_off_b", int'(ob0), 0);
        chk("mcal_off_c", int'(oc0), -8);
        strobe(125, 100, -8);
        chk("mrun_ov", int'(ov0), 1);
        chk("mrun_ia", int'(ia0), 100);
        chk("mrun_ib", int'(ib0), 100);
        chk("mrun_ic", int'(ic0), 0);
        chk("mrun_err", int'(er0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
